dmem_responder: RTL and testbench

// - Responder end of the memory-stage data request interface.
// - Accepts one load or store request at a time, services it from an internal

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-side memory responder: serialises one load or store at a time against an
// internal word RAM, completing each request a fixed number of cycles after accept.
module dmem_responder #(
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rreq_valid,
    input  logic [31:0] rreq_addr,
    input  logic [2:0]  rreq_size,
    input  logic        wreq_valid,
    input  logic [31:0] wreq_addr,
    input  logic [2:0]  wreq_size,
    input  logic [31:0] wreq_data,
    input  logic [3:0]  wreq_strobe,
    output logic [31:0] rd,
    output logic        data_ok,
    output logic        busy
);

    localparam int          CNT_W = $clog2(LATENCY + 1);
    localparam logic [32:0] SPAN  = 33'd4 << ADDR_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CNT_W-1:0]       cnt;
    logic                   lat_write;
    logic [31:0]            lat_addr;
    logic [31:0]            lat_data;
    logic [3:0]             lat_strobe;
    logic [31:0]            mem [0:(2**ADDR_BITS)-1];

    logic                   req;
    logic                   cur_write;
    logic [31:0]            cur_addr;
    logic [31:0]            cur_off;
    logic [31:0]            lat_off;
    logic                   cur_in_range;
    logic                   lat_in_range;
    logic [ADDR_BITS-1:0]   cur_idx;
    logic [ADDR_BITS-1:0]   lat_idx;
    logic                   unused_bits;

    assign req         = rreq_valid | wreq_valid;
    assign unused_bits = ^{rreq_size, wreq_size, cur_off[1:0], lat_off[1:0]};

    // In IDLE the live inputs describe the request; afterwards the latched copy does.
    // A store wins over a simultaneous load.
    always_comb begin
        cur_write = lat_write;
        cur_addr  = lat_addr;
        if (state == S_IDLE) begin
            cur_write = wreq_valid;
            cur_addr  = wreq_valid ? wreq_addr : rreq_addr;
        end
        cur_off      = cur_addr - BASE_ADDR;
        lat_off      = lat_addr - BASE_ADDR;
        cur_in_range = {1'b0, cur_off} < SPAN;
        lat_in_range = {1'b0, lat_off} < SPAN;
        cur_idx      = cur_off[ADDR_BITS+1:2];
        lat_idx      = lat_off[ADDR_BITS+1:2];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    next_state = (LATENCY > 1) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        data_ok = (state == S_DONE);
        busy    = req & ~data_ok;
    end

    // rd is loaded on the edge entering DONE so it appears alongside data_ok.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt        <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_strobe <= '0;
            rd         <= '0;
        end else begin
            if (state == S_IDLE && req) begin
                lat_write  <= wreq_valid;
                lat_addr   <= wreq_valid ? wreq_addr : rreq_addr;
                lat_data   <= wreq_data;
                lat_strobe <= wreq_strobe;
                cnt        <= CNT_W'(LATENCY - 1);
            end else if (state == S_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (next_state == S_DONE && !cur_write) begin
                rd <= cur_in_range ? mem[cur_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_DONE && lat_write && lat_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_strobe[i]) begin
                    mem[lat_idx][8*i +: 8] <= lat_data[8*i +: 8];
                end
            end
        end
    end

    // Requesters must never present a load and a store in the same cycle.
    a_no_dual_request: assert property (
        @(posedge clk) disable iff (!resetn)
        (state == S_IDLE) |-> !(rreq_valid && wreq_valid)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance for functional
// scenarios and one LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic        clk;
    logic        resetn;

    logic        rreq_valid, wreq_valid;
    logic [31:0] rreq_addr, wreq_addr, wreq_data;
    logic [2:0]  rreq_size, wreq_size;
    logic [3:0]  wreq_strobe;
    logic [31:0] rd;
    logic        data_ok, busy;

    logic        rreq_valid2, wreq_valid2;
    logic [31:0] rreq_addr2, wreq_addr2, wreq_data2;
    logic [2:0]  rreq_size2, wreq_size2;
    logic [3:0]  wreq_strobe2;
    logic [31:0] rd2;
    logic        data_ok2, busy2;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.LATENCY(2), .ADDR_BITS(10), .BASE_ADDR(32'h8000_0000)) dut (
        .clk(clk), .resetn(resetn),
        .rreq_valid(rreq_valid), .rreq_addr(rreq_addr), .rreq_size(rreq_size),
        .wreq_valid(wreq_valid), .wreq_addr(wreq_addr), .wreq_size(wreq_size),
        .wreq_data(wreq_data), .wreq_strobe(wreq_strobe),
        .rd(rd), .data_ok(data_ok), .busy(busy)
    );

    dmem_responder #(.LATENCY(1), .ADDR_BITS(10), .BASE_ADDR(32'h8000_0000)) dut2 (
        .clk(clk), .resetn(resetn),
        .rreq_valid(rreq_valid2), .rreq_addr(rreq_addr2), .rreq_size(rreq_size2),
        .wreq_valid(wreq_valid2), .wreq_addr(wreq_addr2), .wreq_size(wreq_size2),
        .wreq_data(wreq_data2), .wreq_strobe(wreq_strobe2),
        .rd(rd2), .data_ok(data_ok2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Holds a request until data_ok, then drops it. n counts cycles from accept to data_ok.
    task automatic issue(input bit which, input bit is_write, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] strb,
                         output int n, output logic [31:0] rd_ok,
                         output bit busy_pre, output bit busy_ok);
        bit seen;
        seen     = 1'b0;
        n        = 0;
        busy_pre = 1'b1;
        busy_ok  = 1'b1;
        rd_ok    = 'x;
        if (!which) begin
            if (is_write) begin
                wreq_valid = 1'b1; wreq_addr = addr; wreq_data = data; wreq_strobe = strb;
            end else begin
                rreq_valid = 1'b1; rreq_addr = addr;
            end
        end else begin
            if (is_write) begin
                wreq_valid2 = 1'b1; wreq_addr2 = addr; wreq_data2 = data; wreq_strobe2 = strb;
            end else begin
                rreq_valid2 = 1'b1; rreq_addr2 = addr;
            end
        end
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (which ? data_ok2 : data_ok) begin
                seen    = 1'b1;
                rd_ok   = which ? rd2 : rd;
                busy_ok = which ? busy2 : busy;
            end else begin
                n++;
                if (!(which ? busy2 : busy)) busy_pre = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (!which) begin
            wreq_valid = 1'b0; rreq_valid = 1'b0;
        end else begin
            wreq_valid2 = 1'b0; rreq_valid2 = 1'b0;
        end
        if (!seen) n = -1;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #12;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd: got %h expected %h", rd, 32'h0); end
        checks++; if (data_ok !== 1'b0) begin errors++; $display("[TB] FAIL reset_data_ok: got %b expected 0", data_ok); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rd, data_ok, busy} !== 34'h0) begin
                errors++;
                $display("[TB] FAIL idle_outputs: got rd=%h ok=%b busy=%b expected all 0", rd, data_ok, busy);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        int n; logic [31:0] r; bit bp, bo;
        issue(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, n, r, bp, bo);
        checks++; if (n !== 2) begin errors++; $display("[TB] FAIL store_latency: got %0d expected 2", n); end
        checks++; if (bp !== 1'b1) begin errors++; $display("[TB] FAIL store_busy_pending: got %b expected 1", bp); end
        checks++; if (bo !== 1'b0) begin errors++; $display("[TB] FAIL store_busy_at_ok: got %b expected 0", bo); end
        issue(0, 0, 32'h8000_0010, 32'h0, 4'h0, n, r, bp, bo);
        checks++; if (n !== 2) begin errors++; $display("[TB] FAIL load_latency: got %0d expected 2", n); end
        checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL load_data: got %h expected %h", r, 32'hDEAD_BEEF); end
    endtask

    task automatic test_partial_strobe;
        int n; logic [31:0] r; bit bp, bo;
        issue(0, 1, 32'h8000_0020, 32'h1122_3344, 4'hF, n, r, bp, bo);
        issue(0, 1, 32'h8000_0020, 32'h00AB_0000, 4'b0100, n, r, bp, bo);
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_hold_over_store: got %h expected %h", rd, 32'hDEAD_BEEF); end
        issue(0, 0, 32'h8000_0020, 32'h0, 4'h0, n, r, bp, bo);
        checks++; if (r !== 32'h11AB_3344) begin errors++; $display("[TB] FAIL partial_strobe: got %h expected %h", r, 32'h11AB_3344); end
    endtask

    task automatic test_out_of_range;
        int n; logic [31:0] r; bit bp, bo;
        issue(0, 0, 32'h0000_0100, 32'h0, 4'h0, n, r, bp, bo);
        checks++; if (n !== 2) begin errors++; $display("[TB] FAIL oor_load_latency: got %0d expected 2", n); end
        checks++; if (r !== 32'h0) begin errors++; $display("[TB] FAIL oor_load_data: got %h expected %h", r, 32'h0); end
        issue(0, 1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, n, r, bp, bo);
        issue(0, 1, 32'h9000_0000, 32'hFFFF_FFFF, 4'hF, n, r, bp, bo);
        checks++; if (n !== 2) begin errors++; $display("[TB] FAIL oor_store_latency: got %0d expected 2", n); end
        issue(0, 1, 32'h8000_1000, 32'h5555_5555, 4'hF, n, r, bp, bo);
        issue(0, 0, 32'h8000_0000, 32'h0, 4'h0, n, r, bp, bo);
        checks++; if (r !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL oor_store_dropped: got %h expected %h", r, 32'hCAFE_F00D); end
        issue(0, 1, 32'h8000_0FFC, 32'hA5A5_5A5A, 4'hF, n, r, bp, bo);
        issue(0, 0, 32'h8000_0FFC, 32'h0, 4'h0, n, r, bp, bo);
        checks++; if (r !== 32'hA5A5_5A5A) begin errors++; $display("[TB] FAIL last_word: got %h expected %h", r, 32'hA5A5_5A5A); end
    endtask

    task automatic test_reset_mid_wait;
        int n; logic [31:0] r; bit bp, bo; bit ok_seen;
        wreq_valid = 1'b1; wreq_addr = 32'h8000_0010; wreq_data = 32'h1234_5678; wreq_strobe = 4'hF;
        @(posedge clk); #1;
        checks++; if (data_ok !== 1'b0) begin errors++; $display("[TB] FAIL wait_data_ok: got %b expected 0", data_ok); end
        #1;
        resetn = 1'b0; wreq_valid = 1'b0;
        #1;
        checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rd: got %h expected %h", rd, 32'h0); end
        @(posedge clk); #1;
        resetn = 1'b1;
        ok_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (data_ok) ok_seen = 1'b1;
        end
        checks++; if (ok_seen !== 1'b0) begin errors++; $display("[TB] FAIL aborted_data_ok: got %b expected 0", ok_seen); end
        @(posedge clk); #1;
        issue(0, 0, 32'h8000_0010, 32'h0, 4'h0, n, r, bp, bo);
        checks++; if (r !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL aborted_store_ram: got %h expected %h", r, 32'hDEAD_BEEF); end
    endtask

    task automatic test_back_to_back;
        int n; logic [31:0] r; bit bp, bo;
        issue(1, 1, 32'h8000_0040, 32'h0BAD_CAFE, 4'hF, n, r, bp, bo);
        checks++; if (n !== 1) begin errors++; $display("[TB] FAIL lat1_store_latency: got %0d expected 1", n); end
        issue(1, 1, 32'h8000_0044, 32'h1357_9BDF, 4'hF, n, r, bp, bo);
        rreq_valid2 = 1'b1; rreq_addr2 = 32'h8000_0040;
        @(negedge clk);
        checks++; if (data_ok2 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_t0_ok: got %b expected 0", data_ok2); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (data_ok2 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_t1_ok: got %b expected 1", data_ok2); end
        checks++; if (rd2 !== 32'h0BAD_CAFE) begin errors++; $display("[TB] FAIL b2b_t1_rd: got %h expected %h", rd2, 32'h0BAD_CAFE); end
        @(posedge clk); #1;
        rreq_addr2 = 32'h8000_0044;
        @(negedge clk);
        checks++; if (data_ok2 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_t2_ok: got %b expected 0", data_ok2); end
        checks++; if (rd2 !== 32'h0BAD_CAFE) begin errors++; $display("[TB] FAIL b2b_t2_rd_hold: got %h expected %h", rd2, 32'h0BAD_CAFE); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (data_ok2 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_t3_ok: got %b expected 1", data_ok2); end
        checks++; if (rd2 !== 32'h1357_9BDF) begin errors++; $display("[TB] FAIL b2b_t3_rd: got %h expected %h", rd2, 32'h1357_9BDF); end
        @(posedge clk); #1;
        rreq_valid2 = 1'b0;
        @(negedge clk);
        checks++; if (data_ok2 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_t4_ok: got %b expected 0", data_ok2); end
        @(posedge clk); #1;
    endtask

    initial begin
        resetn = 1'b0;
        rreq_valid = 1'b0; rreq_addr = '0; rreq_size = 3'd2;
        wreq_valid = 1'b0; wreq_addr = '0; wreq_size = 3'd2; wreq_data = '0; wreq_strobe = '0;
        rreq_valid2 = 1'b0; rreq_addr2 = '0; rreq_size2 = 3'd2;
        wreq_valid2 = 1'b0; wreq_addr2 = '0; wreq_size2 = 3'd2; wreq_data2 = '0; wreq_strobe2 = '0;
        test_reset();
        test_store_load();
        test_partial_strobe();
        test_out_of_range();
        test_reset_mid_wait();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
